// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit, 4-register MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, counts retired instructions, halts on illegal opcodes.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    HALT      = 4'd15
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               illegal_q, illegal_d;

  logic pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c, done_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    i_or_d      = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    pc_source   = 2'b00;

    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b01;
        alu_op     = 3'b010;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: state_d = EXECUTE;
          OP_LW, OP_SW:                                   state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:                                 state_d = BRANCH;
          default:                                        state_d = HALT;
        endcase
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        state_d   = R_WB;
        if (opcode == OP_ADDI) begin
          alu_src_b = 2'b10;
          alu_op    = 3'b010;
        end else begin
          case (opcode)
            OP_SUB:  alu_op = 3'b110;
            OP_AND:  alu_op = 3'b000;
            OP_OR:   alu_op = 3'b001;
            OP_SLT:  alu_op = 3'b111;
            default: alu_op = 3'b010;
          endcase
        end
      end
      R_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = (opcode != OP_ADDI);
        done_c      = 1'b1;
        state_d     = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read_c = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        done_c      = 1'b1;
        state_d     = FETCH;
      end
      MEM_WRITE: begin
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b110;
        pc_source  = 2'b01;
        pc_write_c = (opcode == OP_BEQ) ? zero : ~zero;
        done_c     = 1'b1;
        state_d    = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Strobes are gated by reset so nothing can commit while reset is held.
  assign pc_write   = pc_write_c  & reset_n;
  assign ir_write   = ir_write_c  & reset_n;
  assign mem_read   = mem_read_c  & reset_n;
  assign mem_write  = mem_write_c & reset_n;
  assign reg_write  = reg_write_c & reset_n;
  assign instr_done = done_c      & reset_n;

  assign instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, done_c};
  assign illegal_d     = illegal_q | (state_d == HALT);

  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, corner sequences,
// and randomized instruction streams checked against an instruction-level reference model.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clock, reset_n;
  logic [3:0]       opcode;
  logic             zero, mem_ready;
  logic             pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic             reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, pc_source;
  logic [2:0]       alu_op;
  logic [3:0]       state;
  logic             instr_done, illegal;
  logic [CNT_W-1:0] instr_count;

  int total, passed, modelCount;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] strb;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [5:0] misc;
    logic [3:0] cnt;
  } vec_t;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .instr_count(instr_count), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic z, input logic rdy);
    opcode = op; zero = z; mem_ready = rdy;
    @(negedge clock);
  endtask

  task automatic nextCycle();
    @(posedge clock); #1;
  endtask

  function automatic logic [5:0] strobes();
    return {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done};
  endfunction

  function automatic out_t dutOut();
    out_t o;
    o = '{state, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
          alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal};
    return o;
  endfunction

  // Expected outputs for one step of an instruction, straight from the per-phase output rules.
  function automatic out_t expOut(input byte step, input logic [3:0] op, input logic z, input logic rdy);
    out_t e;
    e = '0;
    case (step)
      "F": begin e.state = 0; e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 3'b010;
                 e.ir_write = rdy; e.pc_write = rdy; end
      "D": begin e.state = 1; e.alu_src_b = 2'b11; e.alu_op = 3'b010; end
      "E": begin
        e.state = 6; e.alu_src_a = 1;
        case (op)
          4'h4: begin e.alu_src_b = 2'b10; e.alu_op = 3'b010; end
          4'h1: e.alu_op = 3'b110;
          4'h2: e.alu_op = 3'b000;
          4'h3: e.alu_op = 3'b001;
          4'h7: e.alu_op = 3'b111;
          default: e.alu_op = 3'b010;
        endcase
      end
      "W": begin e.state = 7; e.reg_write = 1; e.reg_dst = (op != 4'h4); e.instr_done = 1; end
      "A": begin e.state = 2; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 3'b010; end
      "R": begin e.state = 3; e.mem_read = 1; e.i_or_d = 1; end
      "M": begin e.state = 4; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      "S": begin e.state = 5; e.mem_write = 1; e.i_or_d = 1; e.instr_done = rdy; end
      "B": begin e.state = 8; e.alu_src_a = 1; e.alu_op = 3'b110; e.pc_source = 2'b01;
                 e.pc_write = (op == 4'h8) ? z : ~z; e.instr_done = 1; end
      "H": begin e.state = 15; e.illegal = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic runInstr(input logic [3:0] op, input bit randomReady);
    string s;
    int idx, guard;
    byte ch;
    logic rdy, z;
    out_t e;
    case (op)
      4'h5:       s = "FDARM";
      4'h6:       s = "FDAS";
      4'h8, 4'h9: s = "FDB";
      default:    s = "FDEW";
    endcase
    idx = 0; guard = 0;
    while (idx < s.len()) begin
      ch  = s[idx];
      rdy = 1'b1;
      if (randomReady && guard < 20) rdy = ($urandom_range(0, 3) != 0);
      z = ($urandom_range(0, 1) == 1);
      applyStimulus(op, z, rdy);
      e = expOut(ch, op, z, rdy);
      checkOutput("outputs", 32'(dutOut()), 32'(e));
      checkOutput("instr_count", 32'(instr_count), 32'(modelCount));
      if (e.instr_done) modelCount = (modelCount + 1) % (1 << CNT_W);
      if (!(ch == "F" || ch == "R" || ch == "S") || rdy) idx++;
      guard++;
      nextCycle();
    end
  endtask

  task automatic doBranch(input logic [3:0] op, input logic z, input logic expPcw, input string name);
    applyStimulus(op, z, 1'b1); nextCycle();
    applyStimulus(op, z, 1'b1); nextCycle();
    applyStimulus(op, z, 1'b1);
    checkOutput({name, "_state"}, 32'(state), 32'd8);
    checkOutput({name, "_pc_write"}, 32'(pc_write), 32'(expPcw));
    checkOutput({name, "_pc_source"}, 32'(pc_source), 32'd1);
    nextCycle();
    checkOutput({name, "_back_to_fetch"}, 32'(state), 32'd0);
  endtask

  initial begin
    vec_t vecs[13];
    logic [3:0] legal[10];
    int swWrites, swDone, firstW, lastW;
    logic swRdy[7];

    total = 0; passed = 0; modelCount = 0;
    reset_n = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b1;

    vecs[0]  = '{4'h0, 1'b0, 1'b1, 4'd0, 6'b111000, 2'b01, 3'b010, 6'b000000, 4'd0};
    vecs[1]  = '{4'h0, 1'b0, 1'b1, 4'd1, 6'b000000, 2'b11, 3'b010, 6'b000000, 4'd0};
    vecs[2]  = '{4'h0, 1'b0, 1'b1, 4'd6, 6'b000000, 2'b00, 3'b010, 6'b000100, 4'd0};
    vecs[3]  = '{4'h0, 1'b0, 1'b1, 4'd7, 6'b000011, 2'b00, 3'b000, 6'b100000, 4'd0};
    vecs[4]  = '{4'h5, 1'b0, 1'b1, 4'd0, 6'b111000, 2'b01, 3'b010, 6'b000000, 4'd1};
    vecs[5]  = '{4'h5, 1'b0, 1'b1, 4'd1, 6'b000000, 2'b11, 3'b010, 6'b000000, 4'd1};
    vecs[6]  = '{4'h5, 1'b0, 1'b1, 4'd2, 6'b000000, 2'b10, 3'b010, 6'b000100, 4'd1};
    vecs[7]  = '{4'h5, 1'b0, 1'b1, 4'd3, 6'b001000, 2'b00, 3'b000, 6'b001000, 4'd1};
    vecs[8]  = '{4'h5, 1'b0, 1'b1, 4'd4, 6'b000011, 2'b00, 3'b000, 6'b010000, 4'd1};
    vecs[9]  = '{4'h8, 1'b1, 1'b1, 4'd0, 6'b111000, 2'b01, 3'b010, 6'b000000, 4'd2};
    vecs[10] = '{4'h8, 1'b1, 1'b1, 4'd1, 6'b000000, 2'b11, 3'b010, 6'b000000, 4'd2};
    vecs[11] = '{4'h8, 1'b1, 1'b1, 4'd8, 6'b100001, 2'b00, 3'b110, 6'b000101, 4'd2};
    vecs[12] = '{4'h0, 1'b0, 1'b0, 4'd0, 6'b001000, 2'b01, 3'b010, 6'b000000, 4'd3};
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};

    // Reset, then a reset pulse in the middle of a waiting fetch.
    repeat (2) @(posedge clock);
    #1;
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("reset_strobes", 32'(strobes()), 32'd0);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_count", 32'(instr_count), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    nextCycle();
    reset_n = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("fetch_wait", 32'(dutOut()), 32'(expOut("F", 4'h0, 1'b0, 1'b0)));
    nextCycle();
    reset_n = 1'b0;
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("midfetch_reset_strobes", 32'(strobes()), 32'd0);
    checkOutput("midfetch_reset_state", 32'(state), 32'd0);
    nextCycle();
    reset_n = 1'b1;

    // ADD, LW, BEQ taken, then a stalled fetch.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].z, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      checkOutput($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(vecs[i].strb));
      checkOutput($sformatf("vec%0d_alu_src_b", i), 32'(alu_src_b), 32'(vecs[i].srcb));
      checkOutput($sformatf("vec%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].aluop));
      checkOutput($sformatf("vec%0d_misc", i), 32'({reg_dst, mem_to_reg, i_or_d, alu_src_a, pc_source}), 32'(vecs[i].misc));
      checkOutput($sformatf("vec%0d_count", i), 32'(instr_count), 32'(vecs[i].cnt));
      nextCycle();
    end

    // SW with three wait cycles in MEM_WRITE; ready is low in DECODE/MEM_ADDR too and must be ignored.
    swRdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    swWrites = 0; swDone = 0; firstW = -1; lastW = -1;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(4'h6, 1'b0, swRdy[c]);
      if (mem_write) begin
        swWrites++;
        if (firstW < 0) firstW = c;
        lastW = c;
      end
      if (instr_done) swDone++;
      nextCycle();
    end
    checkOutput("sw_mem_write_cycles", 32'(swWrites), 32'd4);
    checkOutput("sw_mem_write_span", 32'(lastW - firstW + 1), 32'd4);
    checkOutput("sw_done_pulses", 32'(swDone), 32'd1);
    checkOutput("sw_back_to_fetch", 32'(state), 32'd0);
    checkOutput("sw_count", 32'(instr_count), 32'd4);

    doBranch(4'h8, 1'b0, 1'b0, "beq_nt");
    doBranch(4'h9, 1'b1, 1'b0, "bne_nt");
    doBranch(4'h9, 1'b0, 1'b1, "bne_t");
    checkOutput("branch_count", 32'(instr_count), 32'd7);

    // Random legal instruction stream with random wait states.
    modelCount = 7;
    for (int n = 0; n < 40; n++) runInstr(legal[$urandom_range(0, 9)], 1'b1);

    // Reset while a store is waiting: the write must not complete.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'h6, 1'b0, 1'b1);
      nextCycle();
    end
    applyStimulus(4'h6, 1'b0, 1'b0);
    checkOutput("sw_abandon_pre", 32'(mem_write), 32'd1);
    nextCycle();
    reset_n = 1'b0;
    applyStimulus(4'h6, 1'b0, 1'b1);
    checkOutput("sw_abandon_strobes", 32'(strobes()), 32'd0);
    checkOutput("sw_abandon_state", 32'(state), 32'd0);
    nextCycle();
    reset_n = 1'b1;
    modelCount = 0;

    // Illegal opcode halts for good until reset.
    runInstr(4'h0, 1'b0);
    applyStimulus(4'hF, 1'b0, 1'b1);
    checkOutput("illegal_fetch", 32'(dutOut()), 32'(expOut("F", 4'hF, 1'b0, 1'b1)));
    nextCycle();
    applyStimulus(4'hF, 1'b0, 1'b1);
    checkOutput("illegal_decode", 32'(dutOut()), 32'(expOut("D", 4'hF, 1'b0, 1'b1)));
    nextCycle();
    for (int c = 0; c < 12; c++) begin
      logic z, r;
      z = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      applyStimulus(4'hF, z, r);
      checkOutput($sformatf("halt%0d", c), 32'(dutOut()), 32'(expOut("H", 4'hF, z, r)));
      nextCycle();
    end
    checkOutput("halt_count", 32'(instr_count), 32'(modelCount));
    reset_n = 1'b0;
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("halt_reset_illegal", 32'(illegal), 32'd0);
    checkOutput("halt_reset_state", 32'(state), 32'd0);
    nextCycle();
    reset_n = 1'b1;
    modelCount = 0;

    // 17 ADDIs wrap the 4-bit counter back to 1.
    for (int n = 0; n < 17; n++) runInstr(4'h4, 1'b0);
    checkOutput("wrap_count", 32'(instr_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
